alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised two-stage pipelined ALU: successor to the single-register operand-select unit.
- Generalised to any data width and an 8-operation set, with carry/zero flags.
- Adds a full valid/ready handshake on input and output with backpressure.
- Sits between the pixel/control datapath producer and its consumer in the vga pipeline; used for coordinate arithmetic and colour masking.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- OP_W, 3, opcode width; fixed at 3, exposed for port sizing only.

Ports:
- clk  input  1  system clock, rising-edge.
- resetn  input  1  asynchronous active-low reset.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- op_in  input  OP_W  opcode.
- valid_in  input  1  input transaction valid.
- ready_in  output  1  block can accept an input this cycle.
- result_out  output  WIDTH  result of stage-2 transaction.
- carry_out  output  1  carry (ADD) / borrow (SUB); 0 for other ops.
- zero_out  output  1  result_out == 0.
- valid_out  output  1  output transaction valid.
- ready_out  input  1  downstream accepts output this cycle.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While resetn=0, all state clears asynchronously: stage valids 0, result_out 0, carry_out 0, zero_out 0, valid_out 0. Reset mid-operation discards in-flight transactions without emitting them.
- Opcodes:
  - 000 PASS_A
  - 001 PASS_B
  - 010 ADD (a+b)
  - 011 SUB (a-b)
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 NOT_A (~a)
- Arithmetic: computed in WIDTH+1 bits. ADD carry = bit WIDTH of the sum. SUB carry = borrow = (a<b unsigned). Results wrap modulo 2^WIDTH.
- Pipeline stages:
  - Stage 1 registers a, b, op and s1_valid.
  - Stage 2 computes from the stage-1 registers and registers result, carry, zero and valid_out.
- Handshake rules:
  - Input accepted on a cycle with valid_in & ready_in.
  - Output consumed on a cycle with valid_out & ready_out.
  - s2_adv = ~valid_out | ready_out.
  - s1_adv = ~s1_valid | s2_adv.
  - ready_in = s1_adv (combinational from ready_out; documented path).
- Latency: input accepted at edge N appears on valid_out after edge N+1 (2 cycles, no stall). Throughput is 1 per cycle with ready_out held 1.
- Stall: while valid_out=1 & ready_out=0, result_out, carry_out, zero_out and valid_out hold stable. Stage 1 holds if s1_valid=1. ready_in drops only when both stages are full.
- Simultaneous events: accept and emit in the same cycle is legal. A full pipeline with ready_out=1 accepts a new input in the same cycle.
- Bubble: when s1_valid=0 and s2_adv=1, valid_out clears on the next edge and data registers hold their previous value.
- Unaccepted inputs (valid_in=0 or ready_in=0) are ignored; operand values are don't-care when valid_in=0.
- The block never drops or duplicates a transaction. Order is preserved.

Optional Feature:
- Macro: ALU_PIPE_SAT_EN.
- Defined:
  - ADD with carry=1 yields result all-ones.
  - SUB with borrow=1 yields result 0.
  - carry_out still reports the unsaturated carry/borrow.
  - zero_out reflects the saturated result.
- Undefined: ADD/SUB wrap modulo 2^WIDTH. No extra logic is compiled.

Test Plan:
- Reset: assert resetn=0 mid-stream with two transactions in flight -> all outputs 0 immediately. After release, no stale valid_out; first new input appears 2 cycles after acceptance.
- Streaming (WIDTH=8, ready_out=1): inputs ADD 0x12+0x34, SUB 0x50-0x10, AND 0xF0&0x3C, XOR 0xAA^0xAA on consecutive cycles -> outputs 0x46 c0 z0, 0x40 c0 z0, 0x30 c0 z0, 0x00 c0 z1 on consecutive cycles, 2-cycle latency.
- Carry/borrow: ADD 0xFF+0x02 -> 0x01 c1 (no SAT) or 0xFF c1 (ALU_PIPE_SAT_EN). SUB 0x05-0x07 -> 0xFE c1 (no SAT) or 0x00 c1 z1 (SAT).
- Backpressure: hold ready_out=0 while sending 3 inputs -> ready_in low after 2 accepted, output held stable. Release ready_out -> the two results drain in order, the third input is accepted in the release cycle, no loss or duplication.
- Ops sweep: PASS_A 0x5A, PASS_B 0xA5, OR 0x0F|0xF0, NOT_A 0x00 -> 0x5A, 0xA5, 0xFF, 0xFF, all c0 z0.
- Random: 10k random ops with random valid_in/ready_out against a scoreboard model -> exact in-order match, valid_out never drops while ready_out=0.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU (8 ops, carry/borrow and zero flags).
// Define ALU_PIPE_SAT_EN to saturate ADD on carry (all-ones) and SUB on borrow (zero).
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [OP_W-1:0]  op_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [WIDTH-1:0] result_out,
    output logic             carry_out,
    output logic             zero_out,
    output logic             valid_out,
    input  logic             ready_out
);
    localparam logic [OP_W-1:0] OP_PASS_A = 3'b000;
    localparam logic [OP_W-1:0] OP_PASS_B = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD    = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB    = 3'b011;
    localparam logic [OP_W-1:0] OP_AND    = 3'b100;
    localparam logic [OP_W-1:0] OP_OR     = 3'b101;
    localparam logic [OP_W-1:0] OP_XOR    = 3'b110;
    localparam logic [OP_W-1:0] OP_NOT_A  = 3'b111;

    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [OP_W-1:0]  s1_op_r;
    logic             s1_valid_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_r;
    logic             zero_r;
    logic             valid_r;

    logic             s2_adv_s;
    logic             s1_adv_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] res_s;
    logic             carry_s;
    logic             zero_s;

    // Handshake: ready_in is combinational from ready_out through both stage-advance terms.
    always_comb begin
        s2_adv_s = ~valid_r | ready_out;
        s1_adv_s = ~s1_valid_r | s2_adv_s;
    end

    assign ready_in   = s1_adv_s;
    assign result_out = res_r;
    assign carry_out  = carry_r;
    assign zero_out   = zero_r;
    assign valid_out  = valid_r;

    // Stage-2 datapath: WIDTH+1-bit arithmetic so bit WIDTH is the carry or borrow.
    always_comb begin
        sum_s   = {1'b0, s1_a_r} + {1'b0, s1_b_r};
        diff_s  = {1'b0, s1_a_r} - {1'b0, s1_b_r};
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        case (s1_op_r)
            OP_PASS_A: res_s = s1_a_r;
            OP_PASS_B: res_s = s1_b_r;
            OP_ADD: begin
                carry_s = sum_s[WIDTH];
`ifdef ALU_PIPE_SAT_EN
                if (sum_s[WIDTH]) begin
                    res_s = {WIDTH{1'b1}};
                end else begin
                    res_s = sum_s[WIDTH-1:0];
                end
`else
                res_s = sum_s[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                carry_s = diff_s[WIDTH];
`ifdef ALU_PIPE_SAT_EN
                if (diff_s[WIDTH]) begin
                    res_s = {WIDTH{1'b0}};
                end else begin
                    res_s = diff_s[WIDTH-1:0];
                end
`else
                res_s = diff_s[WIDTH-1:0];
`endif
            end
            OP_AND:   res_s = s1_a_r & s1_b_r;
            OP_OR:    res_s = s1_a_r | s1_b_r;
            OP_XOR:   res_s = s1_a_r ^ s1_b_r;
            OP_NOT_A: res_s = ~s1_a_r;
            default: begin
                res_s   = {WIDTH{1'b0}};
                carry_s = 1'b0;
            end
        endcase
        zero_s = (res_s == {WIDTH{1'b0}});
    end

    // Stage-1 register: captures operands only for accepted transactions.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= {OP_W{1'b0}};
            s1_valid_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= valid_in;
            if (valid_in) begin
                s1_a_r  <= a_in;
                s1_b_r  <= b_in;
                s1_op_r <= op_in;
            end
        end
    end

    // Stage-2 register: a bubble clears valid but leaves the data registers untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
            valid_r <= 1'b0;
        end else if (s2_adv_s) begin
            valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                res_r   <= res_s;
                carry_r <= carry_s;
                zero_r  <= zero_s;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push hand-computed results; a monitor pops on output handshakes.
module tb_alu_pipe;
    logic       clk;
    logic       resetn;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [2:0] op_in;
    logic       valid_in;
    logic       ready_in;
    logic [7:0] result_out;
    logic       carry_out;
    logic       zero_out;
    logic       valid_out;
    logic       ready_out;

    logic [7:0] exp_r;
    logic       exp_c;
    logic       exp_z;
    logic [9:0] sb[$];
    int         n_cmp;
    int         n_err;
    logic       stall_prev;
    logic [10:0] held;

    alu_pipe #(.WIDTH(8), .OP_W(3)) dut (
        .clk(clk), .resetn(resetn), .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .valid_in(valid_in), .ready_in(ready_in), .result_out(result_out),
        .carry_out(carry_out), .zero_out(zero_out), .valid_out(valid_out),
        .ready_out(ready_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference for random traffic, written from the opcode table.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [7:0] r;
        logic       c;
        r = 8'h00;
        c = 1'b0;
        case (op)
            3'd0: r = a;
            3'd1: r = b;
            3'd2: begin
                c = ({1'b0, a} + {1'b0, b}) > 9'd255;
                r = a + b;
`ifdef ALU_PIPE_SAT_EN
                if (c) r = 8'hFF;
`endif
            end
            3'd3: begin
                c = a < b;
                r = a - b;
`ifdef ALU_PIPE_SAT_EN
                if (c) r = 8'h00;
`endif
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = ~a;
        endcase
        return {c, (r == 8'h00), r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard push: record expected result whenever an input handshake will occur at the next edge.
    always @(negedge clk) begin
        if (resetn && valid_in && ready_in) sb.push_back({exp_c, exp_z, exp_r});
    end

    // Monitor: compare each output handshake in order, and check outputs hold during a stall.
    always @(negedge clk) begin
        if (!resetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_cmp++;
                if ({valid_out, carry_out, zero_out, result_out} !== held) begin
                    n_err++;
                    $display("FAIL stall_hold: got %h expected %h", {valid_out, carry_out, zero_out, result_out}, held);
                end
            end
            if (valid_out && ready_out) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got %h expected none", result_out);
                end else begin
                    logic [9:0] e;
                    e = sb.pop_front();
                    if ({carry_out, zero_out, result_out} !== e) begin
                        n_err++;
                        $display("FAIL result: got c%b z%b %h expected c%b z%b %h",
                                 carry_out, zero_out, result_out, e[9], e[8], e[7:0]);
                    end
                end
            end
            stall_prev = valid_out && !ready_out;
            held = {valid_out, carry_out, zero_out, result_out};
        end
    end

    // Present one transaction (called at posedge+1) and hold it until accepted.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] er, input logic ec, input logic ez);
        int cnt;
        a_in = a; b_in = b; op_in = op; valid_in = 1'b1;
        exp_r = er; exp_c = ec; exp_z = ez;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (ready_in) break;
            cnt++;
            if (cnt > 50) begin
                n_cmp++; n_err++;
                $display("FAIL accept_timeout: got ready_in=0 expected 1");
                break;
            end
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; stall_prev = 1'b0; held = 11'd0;
        a_in = 8'h00; b_in = 8'h00; op_in = 3'd0; valid_in = 1'b0; ready_out = 1'b1;
        exp_r = 8'h00; exp_c = 1'b0; exp_z = 1'b0;
        resetn = 1'b0;
        #1;
        check("reset_outputs", {valid_out, carry_out, zero_out, result_out}, 11'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // Streaming at full rate
        send(8'h12, 8'h34, 3'd2, 8'h46, 1'b0, 1'b0);
        send(8'h50, 8'h10, 3'd3, 8'h40, 1'b0, 1'b0);
        send(8'hF0, 8'h3C, 3'd4, 8'h30, 1'b0, 1'b0);
        send(8'hAA, 8'hAA, 3'd6, 8'h00, 1'b0, 1'b1);
        // Carry and borrow
`ifdef ALU_PIPE_SAT_EN
        send(8'hFF, 8'h02, 3'd2, 8'hFF, 1'b1, 1'b0);
        send(8'h05, 8'h07, 3'd3, 8'h00, 1'b1, 1'b1);
`else
        send(8'hFF, 8'h02, 3'd2, 8'h01, 1'b1, 1'b0);
        send(8'h05, 8'h07, 3'd3, 8'hFE, 1'b1, 1'b0);
`endif
        // Remaining opcodes
        send(8'h5A, 8'h11, 3'd0, 8'h5A, 1'b0, 1'b0);
        send(8'h22, 8'hA5, 3'd1, 8'hA5, 1'b0, 1'b0);
        send(8'h0F, 8'hF0, 3'd5, 8'hFF, 1'b0, 1'b0);
        send(8'h00, 8'h33, 3'd7, 8'hFF, 1'b0, 1'b0);
        repeat (4) @(posedge clk); #1;

        // Backpressure: two fill the pipe, the third enters in the release cycle
        ready_out = 1'b0;
        send(8'h10, 8'h01, 3'd2, 8'h11, 1'b0, 1'b0);
        send(8'hFF, 8'h22, 3'd4, 8'h22, 1'b0, 1'b0);
        fork
            send(8'h30, 8'h03, 3'd5, 8'h33, 1'b0, 1'b0);
            begin
                repeat (3) @(negedge clk);
                check("bp_ready_in_low", {31'd0, ready_in}, 32'd0);
                check("bp_valid_held", {31'd0, valid_out}, 32'd1);
                check("bp_result_held", {24'd0, result_out}, {24'd0, 8'h11});
                @(posedge clk); #1;
                ready_out = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;

        // Reset with two transactions in flight
        send(8'h01, 8'h02, 3'd2, 8'h03, 1'b0, 1'b0);
        a_in = 8'h04; b_in = 8'h04; op_in = 3'd5; valid_in = 1'b1;
        exp_r = 8'h04; exp_c = 1'b0; exp_z = 1'b0;
        @(posedge clk); #2;
        valid_in = 1'b0;
        resetn = 1'b0;
        #1;
        check("midreset_outputs", {valid_out, carry_out, zero_out, result_out}, 11'd0);
        sb.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("post_reset_no_stale", {31'd0, valid_out}, 32'd0);
        send(8'h20, 8'h22, 3'd2, 8'h42, 1'b0, 1'b0);
        check("latency_1edge", {31'd0, valid_out}, 32'd0);
        @(posedge clk); #1;
        check("latency_2edge", {31'd0, valid_out}, 32'd1);
        check("latency_result", {24'd0, result_out}, {24'd0, 8'h42});
        @(posedge clk); #1;

        // Random traffic with random valid_in and ready_out
        for (int i = 0; i < 10000; i++) begin
            logic [9:0] m;
            a_in = 8'($urandom); b_in = 8'($urandom); op_in = 3'($urandom);
            valid_in = ($urandom_range(0, 3) != 0);
            ready_out = ($urandom_range(0, 2) != 0);
            m = model(a_in, b_in, op_in);
            exp_c = m[9]; exp_z = m[8]; exp_r = m[7:0];
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        ready_out = 1'b1;
        begin
            int cnt;
            cnt = 0;
            while (sb.size() != 0 && cnt < 20) begin
                @(posedge clk); #1;
                cnt++;
            end
        end
        check("drain_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
